// File: rtl/spram_wb_arbiter_if.sv
// Bus bundle between N Wishbone masters, the arbiter and the SPRAM slave.
// The arbiter connects via 'slave' (it serves the masters); the surrounding logic uses 'master'.
interface spram_wb_arbiter_if #(
  parameter int N  = 2,
  parameter int AW = 14,
  parameter int DW = 32
);
  localparam int MW = DW / 8;

  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*MW-1:0] m_wmsk;
  logic [N-1:0]    m_we;
  logic [N-1:0]    m_cyc;
  logic [N-1:0]    m_ack;
  logic [DW-1:0]   m_rdata;

  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [MW-1:0]   s_wmsk;
  logic            s_we;
  logic            s_cyc;
  logic            s_ack;
  logic [DW-1:0]   s_rdata;

  logic [N-1:0]    grant;

  modport slave (
    input  m_addr, m_wdata, m_wmsk, m_we, m_cyc, s_ack, s_rdata,
    output m_ack, m_rdata, s_addr, s_wdata, s_wmsk, s_we, s_cyc, grant
  );

  modport master (
    output m_addr, m_wdata, m_wmsk, m_we, m_cyc, s_ack, s_rdata,
    input  m_ack, m_rdata, s_addr, s_wdata, s_wmsk, s_we, s_cyc, grant
  );
endinterface

// File: rtl/spram_wb_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req scanning from last+1, wrapping modulo N.
// Purely combinational; valid is low when req is empty.
module spram_wb_arbiter_rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] idx,
  output logic          valid
);
  always_comb begin
    int j;
    j     = 0;
    idx   = '0;
    valid = 1'b0;
    // Walk from farthest to nearest so the nearest candidate after last wins.
    for (int k = N; k >= 1; k--) begin
      j = (int'(last) + k) % N;
      if (req[j]) begin
        idx   = IW'(j);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/spram_wb_arbiter.sv
// Round-robin arbiter sharing one single-port SPRAM Wishbone slave between N masters.
// One cycle of arbitration from IDLE; on ack the next requester is granted back-to-back.
module spram_wb_arbiter #(
  parameter int N  = 2,
  parameter int AW = 14,
  parameter int DW = 32
) (
  input  logic           clk,
  input  logic           rst,
  spram_wb_arbiter_if.slave bus
);
  localparam int MW = DW / 8;
  localparam int IW = $clog2(N);

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  logic          state;
  logic [IW-1:0] sel;
  logic [IW-1:0] last;

  logic          busy;
  logic [N-1:0]  sel_oh;
  logic [N-1:0]  pick_req;
  logic [IW-1:0] pick_last;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;

  assign busy = (state == BUSY);

  always_comb begin
    sel_oh      = '0;
    sel_oh[sel] = 1'b1;
  end

  // While busy the picker only matters on the ack cycle; the served master is masked out.
  assign pick_req  = busy ? (bus.m_cyc & ~sel_oh) : bus.m_cyc;
  assign pick_last = busy ? sel : last;

  spram_wb_arbiter_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req   (pick_req),
    .last  (pick_last),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
      last  <= IW'(N - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            sel   <= pick_idx;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (bus.s_ack) begin
            last <= sel;
            if (pick_valid) sel   <= pick_idx;
            else            state <= IDLE;
          end else if (!bus.m_cyc[sel]) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s_cyc   = busy & bus.m_cyc[sel];
  assign bus.s_addr  = bus.m_addr [int'(sel)*AW +: AW];
  assign bus.s_wdata = bus.m_wdata[int'(sel)*DW +: DW];
  assign bus.s_wmsk  = bus.m_wmsk [int'(sel)*MW +: MW];
  assign bus.s_we    = bus.m_we[sel];

  // A late ack (master already dropped cyc) is still routed to the granted master.
  assign bus.m_ack   = (busy & bus.s_ack) ? sel_oh : '0;
  assign bus.m_rdata = bus.s_rdata;
  assign bus.grant   = busy ? sel_oh : '0;
endmodule

// File: tb/tb_spram_wb_arbiter.sv
// Directed bench for spram_wb_arbiter with a behavioural SPRAM slave (ack one cycle after cyc).
module tb_spram_wb_arbiter;
  localparam int N  = 2;
  localparam int AW = 14;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  spram_wb_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus ();

  spram_wb_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // SPRAM slave model: acks the cycle after cyc, at most one access per 2 cycles.
  logic [31:0] mem [0:31];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.s_ack   <= 1'b0;
      bus.s_rdata <= '0;
      for (int k = 0; k < 32; k++) mem[k] <= '0;
    end else if (bus.s_cyc && !bus.s_ack) begin
      bus.s_ack   <= 1'b1;
      bus.s_rdata <= mem[bus.s_addr[4:0]];
      if (bus.s_we)
        for (int b = 0; b < 4; b++)
          if (bus.s_wmsk[b]) mem[bus.s_addr[4:0]][b*8 +: 8] <= bus.s_wdata[b*8 +: 8];
    end else begin
      bus.s_ack <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [3:0] msk);
    bus.m_addr[i*AW +: AW]  = a;
    bus.m_wdata[i*DW +: DW] = d;
    bus.m_wmsk[i*4 +: 4]    = msk;
    bus.m_we[i]             = we;
  endtask

  // Single master access from IDLE; lat = cycles from request to ack, -1 on timeout.
  task automatic access(input int i, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [3:0] msk,
                        output logic [31:0] rd, output int lat);
    set_m(i, we, a, d, msk);
    bus.m_cyc[i] = 1'b1;
    lat = -1;
    rd  = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus.m_ack[i]) begin
        rd  = bus.m_rdata;
        lat = c;
        break;
      end
    end
    bus.m_cyc[i] = 1'b0;
    tick();
  endtask

  task automatic rst_pulse();
    bus.m_cyc = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    bus.m_cyc = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.s_cyc !== 1'b0) begin bad++; $display("FAIL reset_s_cyc: got %b want 0", bus.s_cyc); end
    total++; if (bus.m_ack !== 2'b00) begin bad++; $display("FAIL reset_m_ack: got %b want 00", bus.m_ack); end
    total++; if (bus.grant !== 2'b00) begin bad++; $display("FAIL reset_grant: got %b want 00", bus.grant); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    set_m(0, 1'b0, 14'h0005, 32'h0, 4'h0);
    bus.m_cyc = 2'b01;
    tick();
    total++; if (bus.s_cyc !== 1'b1) begin bad++; $display("FAIL busy_s_cyc: got %b want 1", bus.s_cyc); end
    total++; if (bus.grant !== 2'b01) begin bad++; $display("FAIL busy_grant: got %b want 01", bus.grant); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.s_cyc !== 1'b0) begin bad++; $display("FAIL midrst_s_cyc: got %b want 0", bus.s_cyc); end
    total++; if (bus.grant !== 2'b00) begin bad++; $display("FAIL midrst_grant: got %b want 00", bus.grant); end
    total++; if (bus.m_ack !== 2'b00) begin bad++; $display("FAIL midrst_m_ack: got %b want 00", bus.m_ack); end
    bus.m_cyc = '0;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [31:0] rd;
    int lat;
    set_m(0, 1'b1, 14'h0010, 32'hDEADBEEF, 4'hF);
    bus.m_cyc[0] = 1'b1;
    #1;
    total++; if (bus.s_cyc !== 1'b0) begin bad++; $display("FAIL c0_s_cyc: got %b want 0", bus.s_cyc); end
    tick();
    total++; if (bus.s_cyc !== 1'b1) begin bad++; $display("FAIL c1_s_cyc: got %b want 1", bus.s_cyc); end
    total++; if (bus.s_addr !== 14'h0010) begin bad++; $display("FAIL c1_s_addr: got %h want 0010", bus.s_addr); end
    total++; if (bus.s_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL c1_s_wdata: got %h want deadbeef", bus.s_wdata); end
    total++; if (bus.s_we !== 1'b1) begin bad++; $display("FAIL c1_s_we: got %b want 1", bus.s_we); end
    tick();
    total++; if (bus.m_ack !== 2'b01) begin bad++; $display("FAIL c2_m_ack: got %b want 01", bus.m_ack); end
    bus.m_cyc[0] = 1'b0;
    tick();
    access(0, 1'b1, 14'h0010, 32'h12345678, 4'b0011, rd, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL wr2_latency: got %0d want 2", lat); end
    access(0, 1'b0, 14'h0010, 32'h0, 4'h0, rd, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL rd_latency: got %0d want 2", lat); end
    total++; if (rd !== 32'hDEAD5678) begin bad++; $display("FAIL rd_masked: got %h want dead5678", rd); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] rd;
    logic [1:0]  exp_ack;
    int lat;
    rst_pulse();
    set_m(0, 1'b1, 14'h0001, 32'hA5A5A5A5, 4'hF);
    set_m(1, 1'b1, 14'h0002, 32'h5A5A5A5A, 4'hF);
    bus.m_cyc = 2'b11;
    for (int c = 1; c <= 4; c++) begin
      tick();
      exp_ack = (c == 2) ? 2'b01 : (c == 4) ? 2'b10 : 2'b00;
      total++; if (bus.s_cyc !== 1'b1) begin bad++; $display("FAIL sim_s_cyc c%0d: got %b want 1", c, bus.s_cyc); end
      total++; if (bus.m_ack !== exp_ack) begin bad++; $display("FAIL sim_m_ack c%0d: got %b want %b", c, bus.m_ack, exp_ack); end
      if (c == 2) bus.m_cyc[0] = 1'b0;
      if (c == 4) bus.m_cyc[1] = 1'b0;
    end
    tick();
    access(0, 1'b0, 14'h0001, 32'h0, 4'h0, rd, lat);
    total++; if (rd !== 32'hA5A5A5A5) begin bad++; $display("FAIL sim_rd0: got %h want a5a5a5a5", rd); end
    access(1, 1'b0, 14'h0002, 32'h0, 4'h0, rd, lat);
    total++; if (rd !== 32'h5A5A5A5A) begin bad++; $display("FAIL sim_rd1: got %h want 5a5a5a5a", rd); end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_ack;
    logic [31:0] exp_rd;
    int acks;
    acks = 0;
    set_m(0, 1'b0, 14'h0001, 32'h0, 4'h0);
    set_m(1, 1'b0, 14'h0002, 32'h0, 4'h0);
    bus.m_cyc = 2'b11;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c % 2 == 0) exp_ack = ((c / 2) % 2 == 1) ? 2'b01 : 2'b10;
      else            exp_ack = 2'b00;
      total++; if (bus.s_cyc !== 1'b1) begin bad++; $display("FAIL cont_s_cyc c%0d: got %b want 1", c, bus.s_cyc); end
      total++; if (bus.m_ack !== exp_ack) begin bad++; $display("FAIL cont_m_ack c%0d: got %b want %b", c, bus.m_ack, exp_ack); end
      if (exp_ack != 2'b00) begin
        acks++;
        exp_rd = exp_ack[0] ? 32'hA5A5A5A5 : 32'h5A5A5A5A;
        total++; if (bus.m_rdata !== exp_rd) begin bad++; $display("FAIL cont_rdata c%0d: got %h want %h", c, bus.m_rdata, exp_rd); end
      end
    end
    bus.m_cyc = 2'b00;
    tick();
    total++; if (acks !== 8) begin bad++; $display("FAIL cont_ack_count: got %0d want 8", acks); end
    tick();
  endtask

  task automatic test_abort();
    rst_pulse();
    set_m(1, 1'b1, 14'h0003, 32'hFFFFFFFF, 4'hF);
    bus.m_cyc = 2'b10;
    tick();
    total++; if (bus.grant !== 2'b10) begin bad++; $display("FAIL abort_grant1: got %b want 10", bus.grant); end
    bus.m_cyc[1] = 1'b0;
    set_m(0, 1'b0, 14'h0003, 32'h0, 4'h0);
    bus.m_cyc[0] = 1'b1;
    #1;
    total++; if (bus.s_cyc !== 1'b0) begin bad++; $display("FAIL abort_s_cyc: got %b want 0", bus.s_cyc); end
    total++; if (bus.m_ack !== 2'b00) begin bad++; $display("FAIL abort_m_ack: got %b want 00", bus.m_ack); end
    tick();
    total++; if (bus.grant !== 2'b00) begin bad++; $display("FAIL abort_idle_grant: got %b want 00", bus.grant); end
    total++; if (bus.m_ack !== 2'b00) begin bad++; $display("FAIL abort_idle_ack: got %b want 00", bus.m_ack); end
    tick();
    total++; if (bus.grant !== 2'b01) begin bad++; $display("FAIL abort_grant0: got %b want 01", bus.grant); end
    total++; if (bus.s_addr !== 14'h0003) begin bad++; $display("FAIL abort_s_addr: got %h want 0003", bus.s_addr); end
    tick();
    total++; if (bus.m_ack !== 2'b01) begin bad++; $display("FAIL abort_m_ack0: got %b want 01", bus.m_ack); end
    total++; if (bus.m_rdata !== 32'h00000000) begin bad++; $display("FAIL abort_rdata: got %h want 00000000", bus.m_rdata); end
    bus.m_cyc = 2'b00;
    tick();
  endtask

  initial begin
    bus.m_cyc   = '0;
    bus.m_we    = '0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_wmsk  = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_contention();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
